// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the SLC-3 memory responder.
package mem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } mem_state_t;

  localparam logic [15:0] IO_ADDR = 16'hFFFF;
  localparam int          WORD_W  = 16;
endpackage

// File: rtl/mem_responder_array.sv
// Single-port word RAM: synchronous write, combinational read, no reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// SLC-3 memory-side responder: wait-state timing, word RAM, switch/hex I/O word.
// Optional sticky protocol-error flag built when MEM_RESP_ERR_EN is defined.
//
// state | meaning
// IDLE  | waiting for Mem_RD/Mem_WR; operands latched on acceptance
// BUSY  | counting down wait states
// RESP  | access committed, Ready high for this one cycle
// HOLD  | waiting for the CPU to drop its request
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [15:0]       ADDR,
  input  logic [WORD_W-1:0] Data_from_CPU,
  input  logic              Mem_RD,
  input  logic              Mem_WR,
  input  logic [WORD_W-1:0] Switches,
  output logic [WORD_W-1:0] Data_to_CPU,
  output logic              Ready,
  output logic [WORD_W-1:0] HEX_Data,
  output logic              Err
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  mem_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              wr_q;
  logic [WORD_W-1:0] dout_q;
  logic [WORD_W-1:0] hex_q;
  logic              req;
  logic              enter_resp;
  logic [15:0]       op_addr;
  logic [WORD_W-1:0] op_wdata;
  logic              op_wr;
  logic              is_io;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;

  assign req = Mem_RD | Mem_WR;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d = WS;
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_d = req ? HOLD : IDLE;
      HOLD:    if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the commit happens on the accepting edge, so use live operands.
  assign op_addr  = (state_q == IDLE) ? ADDR          : addr_q;
  assign op_wdata = (state_q == IDLE) ? Data_from_CPU : wdata_q;
  assign op_wr    = (state_q == IDLE) ? Mem_WR        : wr_q;
  assign is_io    = (op_addr == IO_ADDR);
  assign ram_we   = enter_resp & op_wr & ~is_io;

  mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk_i   (Clk),
    .we_i    (ram_we),
    .addr_i  (op_addr[ADDR_W-1:0]),
    .wdata_i (op_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      hex_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req) begin
        addr_q  <= ADDR;
        wdata_q <= Data_from_CPU;
        wr_q    <= Mem_WR;
      end
      if (enter_resp) begin
        if (op_wr && is_io) hex_q <= op_wdata;
        if (!op_wr) dout_q <= is_io ? Switches : ram_rdata;
      end
    end
  end

  assign Data_to_CPU = dout_q;
  assign HEX_Data    = hex_q;
  assign Ready       = (state_q == RESP);

`ifdef MEM_RESP_ERR_EN
  logic err_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      err_q <= 1'b0;
    end else if ((state_q == IDLE && Mem_RD && Mem_WR) || (state_q == BUSY && !req)) begin
      err_q <= 1'b1;
    end
  end

  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_STATES=2 instance and a WAIT_STATES=0 instance.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr, wdata, sw;
  logic        rd, wr;
  wire  [15:0] dout, hex;
  wire         rdy, err;
  logic [15:0] addr0, wdata0, sw0;
  logic        rd0, wr0;
  wire  [15:0] dout0, hex0;
  wire         rdy0, err0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .WAIT_STATES(2)) u_dut (
    .Clk(clk), .Reset(rst_n), .ADDR(addr), .Data_from_CPU(wdata),
    .Mem_RD(rd), .Mem_WR(wr), .Switches(sw),
    .Data_to_CPU(dout), .Ready(rdy), .HEX_Data(hex), .Err(err)
  );

  mem_responder #(.ADDR_W(8), .WAIT_STATES(0)) u_dut0 (
    .Clk(clk), .Reset(rst_n), .ADDR(addr0), .Data_from_CPU(wdata0),
    .Mem_RD(rd0), .Mem_WR(wr0), .Switches(sw0),
    .Data_to_CPU(dout0), .Ready(rdy0), .HEX_Data(hex0), .Err(err0)
  );

  // One request/response handshake; lat counts negedges after the accepting edge (-1 on timeout).
  task automatic access(input bit use0, input bit do_wr, input bit both,
                        input logic [15:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] rdata);
    @(negedge clk);
    if (use0) begin
      addr0 = a; wdata0 = d; wr0 = do_wr | both; rd0 = ~do_wr | both;
    end else begin
      addr = a; wdata = d; wr = do_wr | both; rd = ~do_wr | both;
    end
    lat   = -1;
    rdata = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        if (use0) begin addr0 = ~a; wdata0 = ~d; end
        else begin addr = ~a; wdata = ~d; end
      end
      if ((use0 ? rdy0 : rdy) === 1'b1) begin
        lat   = i;
        rdata = use0 ? dout0 : dout;
        break;
      end
    end
    if (use0) begin rd0 = 1'b0; wr0 = 1'b0; end
    else begin rd = 1'b0; wr = 1'b0; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rd = 0; wr = 0; addr = 0; wdata = 0; sw = 0;
    rd0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0; sw0 = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", rdy); end
    n_checks++; if (dout !== 16'h0) begin n_fail++; $display("FAIL reset_dout got %h want 0000", dout); end
    n_checks++; if (hex !== 16'h0) begin n_fail++; $display("FAIL reset_hex got %h want 0000", hex); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_checks++; if (rdy0 !== 1'b0 || dout0 !== 16'h0) begin n_fail++; $display("FAIL reset_ws0 got rdy=%b dout=%h want 0/0000", rdy0, dout0); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat; logic [15:0] r;
    access(0, 1, 0, 16'h0012, 16'hBEEF, lat, r);
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL wr_latency got %0d want 3", lat); end
    @(negedge clk);
    n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL wr_ready_single got %b want 0", rdy); end
    access(0, 0, 0, 16'h0012, 16'h0000, lat, r);
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL rd_latency got %0d want 3", lat); end
    n_checks++; if (r !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data got %h want BEEF", r); end
  endtask

  task automatic test_io();
    int lat; logic [15:0] r;
    access(0, 1, 0, 16'h00FF, 16'h5555, lat, r);
    access(0, 0, 0, 16'h00FF, 16'h0000, lat, r);
    n_checks++; if (r !== 16'h5555) begin n_fail++; $display("FAIL ram_ff_prior got %h want 5555", r); end
    access(0, 1, 0, 16'hFFFF, 16'h1234, lat, r);
    n_checks++; if (hex !== 16'h1234) begin n_fail++; $display("FAIL hex_write got %h want 1234", hex); end
    n_checks++; if (dout !== 16'h5555) begin n_fail++; $display("FAIL dout_held_on_write got %h want 5555", dout); end
    access(0, 0, 0, 16'h00FF, 16'h0000, lat, r);
    n_checks++; if (r !== 16'h5555) begin n_fail++; $display("FAIL ram_ff_untouched got %h want 5555", r); end
    sw = 16'hA5A5;
    access(0, 0, 0, 16'hFFFF, 16'h0000, lat, r);
    n_checks++; if (r !== 16'hA5A5) begin n_fail++; $display("FAIL switch_read got %h want A5A5", r); end
    n_checks++; if (hex !== 16'h1234) begin n_fail++; $display("FAIL hex_held_on_read got %h want 1234", hex); end
  endtask

  task automatic test_alias();
    int lat; logic [15:0] r;
    access(0, 1, 0, 16'h0100, 16'h7777, lat, r);
    access(0, 0, 0, 16'h0000, 16'h0000, lat, r);
    n_checks++; if (r !== 16'h7777) begin n_fail++; $display("FAIL alias_read got %h want 7777", r); end
  endtask

  task automatic test_hold();
    int pulses = 0;
    @(negedge clk);
    addr = 16'h0012; rd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdy === 1'b1) pulses++;
    end
    rd = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rdy === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL hold_pulses got %0d want 1", pulses); end
    n_checks++; if (dout !== 16'hBEEF) begin n_fail++; $display("FAIL hold_data got %h want BEEF", dout); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] r;
    access(1, 1, 0, 16'h0003, 16'h1111, lat, r);
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL ws0_wr_latency got %0d want 1", lat); end
    access(1, 1, 0, 16'h0004, 16'h2222, lat, r);
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL ws0_wr2_latency got %0d want 1", lat); end
    access(1, 0, 0, 16'h0003, 16'h0000, lat, r);
    n_checks++; if (lat != 1 || r !== 16'h1111) begin n_fail++; $display("FAIL ws0_rd1 got lat=%0d data=%h want 1/1111", lat, r); end
    access(1, 0, 0, 16'h0004, 16'h0000, lat, r);
    n_checks++; if (lat != 1 || r !== 16'h2222) begin n_fail++; $display("FAIL ws0_rd2 got lat=%0d data=%h want 1/2222", lat, r); end
    access(1, 1, 0, 16'hFFFF, 16'h4321, lat, r);
    n_checks++; if (hex0 !== 16'h4321) begin n_fail++; $display("FAIL ws0_hex got %h want 4321", hex0); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] r;
    access(0, 1, 0, 16'h0005, 16'h0BAD, lat, r);
    access(0, 0, 0, 16'h0005, 16'h0000, lat, r);
    @(negedge clk);
    addr = 16'h0005; wdata = 16'hDEAD; wr = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (rdy !== 1'b0 || dout !== 16'h0 || hex !== 16'h0) begin
      n_fail++; $display("FAIL midreset_outputs got rdy=%b dout=%h hex=%h want 0/0000/0000", rdy, dout, hex);
    end
    @(negedge clk);
    wr = 1'b0;
    rst_n = 1'b1;
    access(0, 0, 0, 16'h0005, 16'h0000, lat, r);
    n_checks++; if (r !== 16'h0BAD) begin n_fail++; $display("FAIL midreset_ram got %h want 0BAD", r); end
  endtask

  task automatic test_err();
    int lat; logic [15:0] r;
    access(0, 0, 1, 16'h0020, 16'h4242, lat, r);
`ifdef MEM_RESP_ERR_EN
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_both got %b want 1", err); end
`else
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_tied got %b want 0", err); end
`endif
    access(0, 0, 0, 16'h0020, 16'h0000, lat, r);
    n_checks++; if (r !== 16'h4242) begin n_fail++; $display("FAIL both_is_write got %h want 4242", r); end
    access(0, 1, 0, 16'h0021, 16'h9999, lat, r);
`ifdef MEM_RESP_ERR_EN
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", err); end
`else
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_tied_after got %b want 0", err); end
`endif
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_cleared got %b want 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_io();
    test_alias();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
